// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared definitions for the traffic-light phase sequencer:
//                phase codes, lamp codes and the phase-order / phase-length
//                helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package tl_pkg;

   // Phase codes (3-bit, codes 6..7 are illegal)
   localparam logic [2:0] NS_G  = 3'd0;
   localparam logic [2:0] NS_Y  = 3'd1;
   localparam logic [2:0] RED_A = 3'd2;
   localparam logic [2:0] EW_G  = 3'd3;
   localparam logic [2:0] EW_Y  = 3'd4;
   localparam logic [2:0] RED_B = 3'd5;

   // Lamp codes {red,yellow,green}
   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   // Fixed six-phase rotation; anything illegal recovers through RED_A.
   function automatic logic [2:0] next_state(input logic [2:0] s);
      case (s)
         NS_G:    next_state = NS_Y;
         NS_Y:    next_state = RED_A;
         RED_A:   next_state = EW_G;
         EW_G:    next_state = EW_Y;
         EW_Y:    next_state = RED_B;
         RED_B:   next_state = NS_G;
         default: next_state = RED_A;
      endcase
   endfunction

   // Duration of a phase in ticks, given the block's timing parameters.
   function automatic int phase_len(input logic [2:0] s, input int g, input int y,
                                    input int r);
      case (s)
         NS_G, EW_G: phase_len = g;
         NS_Y, EW_Y: phase_len = y;
         default:    phase_len = r;
      endcase
   endfunction

   function automatic logic is_red(input logic [2:0] s);
      is_red = (s == RED_A) || (s == RED_B);
   endfunction

   function automatic logic is_green(input logic [2:0] s);
      is_green = (s == NS_G) || (s == EW_G);
   endfunction

endpackage
`default_nettype wire

// File: rtl/phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : phase_counter
//  Description : CW-bit loadable down-counter holding the ticks left in the
//                current phase. load has priority over dec.
//  Ports       : clk, r_n (async active-low reset), load, load_val[CW], dec,
//                count[CW] (registered value), last (count == 1)
//  Revision    : 1.0  initial release
// ============================================================================
module phase_counter #(
   parameter int CW      = 8,
   parameter int RST_VAL = 1
) (
   input  logic          clk,
   input  logic          r_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          last
);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         r_count <= CW'(RST_VAL);
      end else if (load) begin
         r_count <= load_val;
      end else if (dec) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign count = r_count;
   assign last  = (r_count == CW'(1));

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Six-phase two-road traffic-light sequencer advanced by a 1 s
//                tick strobe, with pedestrian-request green shortening and a
//                walk lamp during the following all-red phase.
//  Ports       : clk, r_n (async active-low reset), tick, hold, ped_req,
//                ns_light[3], ew_light[3] ({red,yellow,green}),
//                remain[CW], phase[3], walk  -- all outputs registered
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
   import tl_pkg::*;
#(
   parameter int G_TIME  = 12,
   parameter int Y_TIME  = 3,
   parameter int R_TIME  = 2,
   parameter int PED_MIN = 4,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          r_n,
   input  logic          tick,
   input  logic          hold,
   input  logic          ped_req,
   output logic [2:0]    ns_light,
   output logic [2:0]    ew_light,
   output logic [CW-1:0] remain,
   output logic [2:0]    phase,
   output logic          walk
);

   logic [2:0]    r_state;
   logic [2:0]    r_ns;
   logic [2:0]    r_ew;
   logic          r_pend;
   logic          r_walk;

   logic [2:0]    w_state_nxt;
   logic [CW-1:0] w_remain;
   logic          w_last;
   logic          w_eff;
   logic          w_illegal;
   logic          w_shorten;
   logic          w_advance;
   logic          w_enter_red;
   logic          w_leave_red;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_dec;

   // Returns {ns_light, ew_light} for a phase.
   function automatic logic [5:0] lights(input logic [2:0] s);
      case (s)
         NS_G:    lights = {L_GRN, L_RED};
         NS_Y:    lights = {L_YEL, L_RED};
         EW_G:    lights = {L_RED, L_GRN};
         EW_Y:    lights = {L_RED, L_YEL};
         default: lights = {L_RED, L_RED};
      endcase
   endfunction

   assign w_eff     = tick & ~hold;
   assign w_illegal = (r_state > RED_B);
   // Shortening is independent of tick and swallows a coincident tick.
   assign w_shorten = ~hold & is_green(r_state) & r_pend & (w_remain > CW'(PED_MIN));
   assign w_advance = ~w_illegal & ~w_shorten & w_eff & w_last;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = w_remain;
      w_dec       = 1'b0;
      if (w_illegal) begin
         w_state_nxt = RED_A;
         w_load      = 1'b1;
         w_load_val  = CW'(R_TIME);
      end else if (w_shorten) begin
         w_load      = 1'b1;
         w_load_val  = CW'(PED_MIN);
      end else if (w_eff) begin
         if (w_last) begin
            w_state_nxt = next_state(r_state);
            w_load      = 1'b1;
            w_load_val  = CW'(phase_len(w_state_nxt, G_TIME, Y_TIME, R_TIME));
         end else begin
            w_dec       = 1'b1;
         end
      end
   end

   assign w_enter_red = w_advance & is_red(w_state_nxt);
   assign w_leave_red = w_advance & is_red(r_state);

   phase_counter #(
      .CW      (CW),
      .RST_VAL (G_TIME)
   ) u_cnt (
      .clk      (clk),
      .r_n      (r_n),
      .load     (w_load),
      .load_val (w_load_val),
      .dec      (w_dec),
      .count    (w_remain),
      .last     (w_last)
   );

   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         r_state <= NS_G;
         r_ns    <= L_GRN;
         r_ew    <= L_RED;
         r_pend  <= 1'b0;
         r_walk  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         {r_ns, r_ew} <= lights(w_state_nxt);
         // A request seen on the red-entry edge survives for the next red.
         r_pend       <= ped_req | (r_pend & ~w_enter_red);
         if (w_illegal) begin
            r_walk <= 1'b0;
         end else if (w_enter_red) begin
            r_walk <= r_pend;
         end else if (w_leave_red) begin
            r_walk <= 1'b0;
         end
      end
   end

   assign ns_light = r_ns;
   assign ew_light = r_ew;
   assign remain   = w_remain;
   assign phase    = r_state;
   assign walk     = r_walk;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Self-checking bench for traffic_light_ctrl. A phase-table
//                reference model tracks phase index, ticks left, pending
//                request and walk; every cycle all outputs are compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_light_ctrl;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          r_n = 1'b0;
   logic          tick = 1'b0;
   logic          hold = 1'b0;
   logic          ped_req = 1'b0;
   logic [2:0]    ns_light;
   logic [2:0]    ew_light;
   logic [CW-1:0] remain;
   logic [2:0]    phase;
   logic          walk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: phase index 0..5 in rotation order.
   int m_ph;
   int m_rem;
   bit m_pend;
   bit m_walk;
   int dur[6]    = '{12, 3, 2, 12, 3, 2};
   int ns_tab[6] = '{1, 2, 4, 4, 4, 4};
   int ew_tab[6] = '{4, 4, 4, 1, 2, 4};

   always #5 clk = ~clk;

   traffic_light_ctrl #(
      .G_TIME  (12),
      .Y_TIME  (3),
      .R_TIME  (2),
      .PED_MIN (4),
      .CW      (CW)
   ) dut (
      .clk      (clk),
      .r_n      (r_n),
      .tick     (tick),
      .hold     (hold),
      .ped_req  (ped_req),
      .ns_light (ns_light),
      .ew_light (ew_light),
      .remain   (remain),
      .phase    (phase),
      .walk     (walk)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_ph   = 0;
      m_rem  = dur[0];
      m_pend = 1'b0;
      m_walk = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit h, input bit p);
      bit old_pend;
      bit enter_red;
      old_pend  = m_pend;
      enter_red = 1'b0;
      if (!h && (m_ph == 0 || m_ph == 3) && old_pend && m_rem > 4) begin
         m_rem = 4;
      end else if (t && !h) begin
         if (m_rem > 1) begin
            m_rem = m_rem - 1;
         end else begin
            if (m_ph == 2 || m_ph == 5) m_walk = 1'b0;
            m_ph  = (m_ph + 1) % 6;
            m_rem = dur[m_ph];
            if (m_ph == 2 || m_ph == 5) begin
               enter_red = 1'b1;
               m_walk    = old_pend;
            end
         end
      end
      m_pend = p | (old_pend & !enter_red);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".phase"}, 32'(phase),    32'(m_ph));
      chk({tag, ".remain"}, 32'(remain),  32'(m_rem));
      chk({tag, ".ns"},    32'(ns_light), 32'(ns_tab[m_ph]));
      chk({tag, ".ew"},    32'(ew_light), 32'(ew_tab[m_ph]));
      chk({tag, ".walk"},  32'(walk),     32'(m_walk));
   endtask

   task automatic cyc(input bit t, input bit h, input bit p, input string tag);
      tick    = t;
      hold    = h;
      ped_req = p;
      @(posedge clk);
      model_step(t, h, p);
      #1;
      check_all(tag);
   endtask

   task automatic ticks(input int n, input string tag);
      repeat (n) cyc(1'b1, 1'b0, 1'b0, tag);
   endtask

   int seq[$];
   int exp_seq[7] = '{0, 1, 2, 3, 4, 5, 0};
   int last_ph;
   bit rt, rh, rp;

   initial begin
      // Reset state
      #12;
      model_reset();
      check_all("reset");
      chk("reset.remain12", 32'(remain), 32'd12);
      r_n = 1'b1;

      // 12 ticks spaced 10 cycles
      seq.push_back(int'(phase));
      last_ph = int'(phase);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b0, 1'b0, "slow");
         if (int'(phase) != last_ph) begin
            seq.push_back(int'(phase));
            last_ph = int'(phase);
         end
         repeat (9) cyc(1'b0, 1'b0, 1'b0, "slow_idle");
      end
      chk("slow.phase_nsy", 32'(phase), 32'd1);
      chk("slow.remain3", 32'(remain), 32'd3);
      chk("slow.ns_yel", 32'(ns_light), 32'b010);

      // Rest of the full cycle
      for (int i = 0; i < 22; i++) begin
         cyc(1'b1, 1'b0, 1'b0, "full");
         if (int'(phase) != last_ph) begin
            seq.push_back(int'(phase));
            last_ph = int'(phase);
         end
         chk("full.walk0", 32'(walk), 32'd0);
         cyc(1'b0, 1'b0, 1'b0, "full_idle");
      end
      chk("full.seq_len", 32'(seq.size()), 32'd7);
      for (int i = 0; i < 7 && i < seq.size(); i++)
         chk("full.seq", 32'(seq[i]), 32'(exp_seq[i]));
      chk("full.remain12", 32'(remain), 32'd12);

      // Pedestrian shortening in NS_G
      ticks(2, "ped1");
      chk("ped1.remain10", 32'(remain), 32'd10);
      cyc(1'b0, 1'b0, 1'b1, "ped1_req");
      cyc(1'b0, 1'b0, 1'b0, "ped1_cut");
      chk("ped1.remain4", 32'(remain), 32'd4);
      ticks(4, "ped1_g");
      chk("ped1.nsy", 32'(phase), 32'd1);
      ticks(3, "ped1_y");
      chk("ped1.walk_on", 32'(walk), 32'd1);
      ticks(1, "ped1_r");
      chk("ped1.walk_hold", 32'(walk), 32'd1);
      ticks(1, "ped1_r");
      chk("ped1.ewg", 32'(phase), 32'd3);
      chk("ped1.walk_off", 32'(walk), 32'd0);

      // Request at remain<=PED_MIN in EW_G, second request on RED_B entry
      ticks(9, "ped2");
      chk("ped2.remain3", 32'(remain), 32'd3);
      cyc(1'b0, 1'b0, 1'b1, "ped2_req");
      cyc(1'b0, 1'b0, 1'b0, "ped2_nocut");
      chk("ped2.remain_kept", 32'(remain), 32'd3);
      ticks(3, "ped2_g");
      ticks(2, "ped2_y");
      cyc(1'b1, 1'b0, 1'b1, "ped2_entry");
      chk("ped2.redb", 32'(phase), 32'd5);
      chk("ped2.walk_on", 32'(walk), 32'd1);
      ticks(2, "ped2_r");
      chk("ped2.nsg12", 32'(remain), 32'd12);
      cyc(1'b0, 1'b0, 1'b0, "ped2_cut");
      chk("ped2.nsg_cut4", 32'(remain), 32'd4);

      // Hold in NS_Y at remain=2
      ticks(5, "hold_pre");
      chk("hold.remain2", 32'(remain), 32'd2);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b1, 1'b0, "hold");
         cyc(1'b0, 1'b1, 1'b0, "hold_idle");
      end
      chk("hold.remain_frozen", 32'(remain), 32'd2);
      chk("hold.phase_frozen", 32'(phase), 32'd1);
      ticks(2, "hold_rel");
      chk("hold.reda", 32'(phase), 32'd2);

      // Asynchronous reset in EW_Y with a pending request
      ticks(2, "ar_pre");
      ticks(12, "ar_ewg");
      chk("ar.ewy", 32'(phase), 32'd4);
      cyc(1'b0, 1'b0, 1'b1, "ar_req");
      ped_req = 1'b0;
      tick    = 1'b0;
      #2;
      r_n = 1'b0;
      #1;
      model_reset();
      check_all("ar_now");
      chk("ar.ns_grn", 32'(ns_light), 32'b001);
      #1;
      r_n = 1'b1;
      ticks(15, "ar_post");
      chk("ar.reda", 32'(phase), 32'd2);
      chk("ar.walk_off", 32'(walk), 32'd0);

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         rt = ($urandom_range(0, 2) == 0);
         rh = ($urandom_range(0, 7) == 0);
         rp = ($urandom_range(0, 19) == 0);
         cyc(rt, rh, rp, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Phase sequencer for a two-road intersection, driven by the one-second enable strobe that feeds the lab timers.
- Holds a loadable per-phase down-counter and walks a fixed six-phase cycle: NS green, NS yellow, all-red, EW green, EW yellow, all-red.
- A latched pedestrian request shortens the current green phase and asserts walk during the following all-red.
- Sits between the 1 s tick source and the light/7-segment display logic on the lab board.

Parameters:
G_TIME, 12, green phase length in ticks (≥1, < 2^CW)
Y_TIME, 3, yellow phase length in ticks (≥1)
R_TIME, 2, all-red phase length in ticks (≥1)
PED_MIN, 4, remaining-green cap applied on pedestrian request (1 ≤ PED_MIN ≤ G_TIME)
CW, 8, width of countdown register

Ports:
clk  in  1  system clock
r_n  in  1  reset; asynchronous, active-low
tick  in  1  one-cycle strobe, one per second (enable pulse)
hold  in  1  level; freezes countdown and phase while high
ped_req  in  1  pedestrian button, synchronous, any length
ns_light  out  3  {red,yellow,green} one-hot for north-south
ew_light  out  3  {red,yellow,green} one-hot for east-west
remain  out  CW  ticks left in current phase (display)
phase  out  3  current state code
walk  out  1  pedestrian walk lamp

Behaviour:
- Reset (r_n=0, async): phase=NS_G, remain=G_TIME, ns_light=001, ew_light=100, walk=0, ped_pend=0. All outputs are registered.
- States and codes: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5. Codes 6–7 are illegal; on the next clk they go to RED_A with remain=R_TIME.
- Lights by state:
  - NS_G: ns 001 / ew 100
  - NS_Y: ns 010 / ew 100
  - RED_A, RED_B: both 100
  - EW_G: ns 100 / ew 001
  - EW_Y: ns 100 / ew 010
- Countdown: an effective tick is tick & ~hold.
  - Effective tick with remain>1: remain−1 on that edge.
  - Effective tick with remain==1: on the same edge, move to the next state and load that phase's duration.
  - Each phase therefore lasts exactly its duration in effective ticks.
  - remain never reaches 0.
- Cycle order: NS_G→NS_Y→RED_A→EW_G→EW_Y→RED_B→NS_G.
- Pedestrian:
  - ped_pend_next = ped_req | (ped_pend & ~enter_red).
  - enter_red is asserted on the edge that moves to RED_A or RED_B.
  - A request arriving on the entry cycle stays pending for the next red.
- Green shortening: when state ∈ {NS_G, EW_G}, ped_pend=1, and remain>PED_MIN, remain loads PED_MIN on the next edge.
  - This applies regardless of tick.
  - If an effective tick occurs in that same cycle, the shortening wins; the tick is absorbed.
  - If remain ≤ PED_MIN, no change.
- walk: set on the edge entering RED_A/RED_B if ped_pend was 1 at that edge; cleared on the edge leaving that red state.
- hold:
  - While high: no decrement, no transition, no green shortening.
  - ped_req still latches.
- r_n asserted mid-phase: immediate return to the reset values; any pending request is discarded.

Decomposition:
- Package tl_pkg:
  - state encoding constants (NS_G..RED_B)
  - light codes (L_RED=100, L_YEL=010, L_GRN=001)
  - function next_state and function phase_len(state)
- Sub-module phase_counter:
  - CW-bit loadable down-counter
  - inputs: load, load_val, dec
  - output: last (remain==1)
  - load has priority over dec.
- The FSM, pedestrian latch and light decode stay in the top.

Test Plan:
- Reset then 12 ticks spaced 10 cycles: phase stays NS_G and remain counts 12→1; the 12th tick enters NS_Y with remain=3 and ns_light=010.
- Full cycle of 34 ticks (12+3+2+12+3+2) returns to NS_G with remain=12; phase sequence is 0,1,2,3,4,5,0; walk is never set.
- ped_req one cycle at remain=10 in NS_G, no tick that cycle: remain=4 next cycle; 4 ticks later the block enters NS_Y; entering RED_A sets walk=1 for 2 ticks; it is cleared on entering EW_G.
- ped_req at remain=3 in EW_G: remain unchanged; walk=1 during RED_B. A second ped_req on the RED_B entry cycle stays pending, so NS_G is cut to 4 on its first cycle.
- hold=1 across 5 ticks in NS_Y at remain=2: remain stays 2 and phase stays 1. After release, 2 ticks reach RED_A.
- r_n pulsed low asynchronously (between edges) in EW_Y with ped_pend=1: outputs go to reset values immediately; ped_pend=0, so the next RED_A has walk=0.
